// File: rtl/bcd7_pkg.sv
// Shared segment patterns and BCD-to-7-segment decode for the scan driver.
// Patterns are active-high, bit order {a,b,c,d,e,f,g}.
package bcd7_pkg;

   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_2    = 7'b1101101;
   localparam logic [6:0] SEG_3    = 7'b1111001;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_5    = 7'b1011011;
   localparam logic [6:0] SEG_6    = 7'b1011111;
   localparam logic [6:0] SEG_7    = 7'b1110000;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1111011;
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   // Non-BCD codes 10..15 render as a dash.
   function automatic logic [6:0] bcd7_decode(input logic [3:0] code);
      logic [6:0] pat;
      case (code)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_DASH;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bcd7_decode_lut.sv
// Combinational 4-to-7 segment decoder applied to the currently scanned digit.
module bcd7_decode_lut
   import bcd7_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = bcd7_decode(code);
   end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed N-digit BCD display driver with a one-word load buffer that
// commits only on frame boundaries, leading-zero blanking and output polarity.
module bcd_7seg_scan_driver
   import bcd7_pkg::*;
#(
   parameter int unsigned N_DIGITS       = 4,
   parameter int unsigned REFRESH_DIV    = 1000,
   parameter bit          SEG_ACTIVE_LOW = 1'b0,
   parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    blank_lz,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*N_DIGITS-1:0]   load_data,
   output logic [6:0]              seg,
   output logic [N_DIGITS-1:0]     dig_en
);

   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned DW = 4 * N_DIGITS;

   localparam logic [PW-1:0]       PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0]       SLOT_LAST  = SW'(N_DIGITS - 1);
   localparam logic [6:0]          SEG_POL    = {7{SEG_ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] DIG_POL    = {N_DIGITS{DIG_ACTIVE_LOW}};

   logic [PW-1:0]       presc_q, presc_d;
   logic [SW-1:0]       slot_q, slot_d;
   logic [DW-1:0]       pending_q, pending_d;
   logic                pend_full_q, pend_full_d;
   logic [DW-1:0]       display_q, display_d;
   logic [6:0]          seg_q, seg_d;
   logic [N_DIGITS-1:0] dig_en_q, dig_en_d;

   logic                tick, frame_start, accept, commit;
   logic                zero_run, cur_blank;
   logic [3:0]          cur_code;
   logic [6:0]          cur_seg;
   logic [N_DIGITS-1:0] blank_vec, dig_onehot;

   assign load_ready = !pend_full_q;

   always_comb begin
      tick        = enable && (presc_q == PRESC_LAST);
      frame_start = tick && (slot_q == SLOT_LAST);
      accept      = load_valid && !pend_full_q;
      // When dark there is no frame to tear, so commit as soon as a word waits.
      commit      = pend_full_q && (frame_start || !enable);

      presc_d = presc_q;
      slot_d  = slot_q;
      if (!enable) begin
         presc_d = '0;
         slot_d  = '0;
      end else if (tick) begin
         presc_d = '0;
         slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end else begin
         presc_d = presc_q + 1'b1;
      end

      pending_d   = accept ? load_data : pending_q;
      display_d   = commit ? pending_q : display_q;
      pend_full_d = pend_full_q;
      if (accept) begin
         pend_full_d = 1'b1;
      end else if (commit) begin
         pend_full_d = 1'b0;
      end
   end

   always_comb begin
      zero_run  = 1'b1;
      blank_vec = '0;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
         zero_run     = zero_run && (display_q[4*i +: 4] == 4'd0);
         blank_vec[i] = blank_lz && zero_run;
      end

      cur_code   = 4'd0;
      cur_blank  = 1'b0;
      dig_onehot = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (slot_q == SW'(i)) begin
            cur_code      = display_q[4*i +: 4];
            cur_blank     = blank_vec[i];
            dig_onehot[i] = 1'b1;
         end
      end
   end

   bcd7_decode_lut u_decode (
      .code (cur_code),
      .seg  (cur_seg)
   );

   always_comb begin
      seg_d    = ((enable && !cur_blank) ? cur_seg : SEG_OFF) ^ SEG_POL;
      dig_en_d = (enable ? dig_onehot : '0) ^ DIG_POL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         slot_q      <= '0;
         pending_q   <= '0;
         pend_full_q <= 1'b0;
         display_q   <= '0;
         seg_q       <= SEG_OFF ^ SEG_POL;
         dig_en_q    <= DIG_POL;
      end else begin
         presc_q     <= presc_d;
         slot_q      <= slot_d;
         pending_q   <= pending_d;
         pend_full_q <= pend_full_d;
         display_q   <= display_d;
         seg_q       <= seg_d;
         dig_en_q    <= dig_en_d;
      end
   end

   assign seg    = seg_q;
   assign dig_en = dig_en_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Scoreboard bench: a cycle-level reference model predicts outputs for two
// drivers (normal and inverted polarity) sharing the same stimulus.
module tb_bcd_7seg_scan_driver;

   localparam int N   = 4;
   localparam int DIV = 4;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] dig;
      logic       rdy;
   } exp_t;

   localparam logic [6:0] SEG_TAB [0:9] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };

   logic        clk, rst_n, enable, blank_lz, load_valid;
   logic [15:0] load_data;
   logic        load_ready, load_ready_inv;
   logic [6:0]  seg, seg_inv;
   logic [3:0]  dig_en, dig_en_inv;

   int checks   = 0;
   int failures = 0;

   exp_t exp_q[$];

   int          m_pos;
   logic        m_full;
   logic [15:0] m_pend, m_disp;

   bcd_7seg_scan_driver #(
      .N_DIGITS       (N),
      .REFRESH_DIV    (DIV),
      .SEG_ACTIVE_LOW (1'b0),
      .DIG_ACTIVE_LOW (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .blank_lz   (blank_lz),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .seg        (seg),
      .dig_en     (dig_en)
   );

   bcd_7seg_scan_driver #(
      .N_DIGITS       (N),
      .REFRESH_DIV    (DIV),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1)
   ) dut_inv (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .blank_lz   (blank_lz),
      .load_valid (load_valid),
      .load_ready (load_ready_inv),
      .load_data  (load_data),
      .seg        (seg_inv),
      .dig_en     (dig_en_inv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [15:0] val, input int slot, input logic lz);
      logic [3:0] d;
      d = 4'((val >> (4 * slot)) & 16'hF);
      if (lz && slot > 0 && (val >> (4 * slot)) == 16'd0) return 7'h00;
      if (d > 4'd9) return 7'b0000001;
      return SEG_TAB[d];
   endfunction

   // Reference model: scan position is a single counter over a whole frame.
   always @(posedge clk) begin : model
      exp_t e;
      int   slot;
      logic acc, fs, com;
      if (!rst_n) begin
         m_pos  = 0;
         m_full = 1'b0;
         m_pend = '0;
         m_disp = '0;
         e.seg  = 7'h00;
         e.dig  = 4'h0;
         e.rdy  = 1'b1;
      end else begin
         slot = m_pos / DIV;
         acc  = load_valid && !m_full;
         fs   = enable && (m_pos == N * DIV - 1);
         com  = m_full && (fs || !enable);
         if (enable) begin
            e.dig = 4'(1 << slot);
            e.seg = ref_seg(m_disp, slot, blank_lz);
         end else begin
            e.dig = 4'h0;
            e.seg = 7'h00;
         end
         m_pos = enable ? (m_pos + 1) % (N * DIV) : 0;
         if (com) begin
            m_disp = m_pend;
            m_full = 1'b0;
         end
         if (acc) begin
            m_pend = load_data;
            m_full = 1'b1;
         end
         e.rdy = !m_full;
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("seg",        32'(seg),            32'(e.seg));
         check("dig_en",     32'(dig_en),         32'(e.dig));
         check("load_ready", 32'(load_ready),     32'(e.rdy));
         check("seg_inv",    32'(seg_inv),        32'(e.seg ^ 7'h7F));
         check("dig_en_inv", 32'(dig_en_inv),     32'(e.dig ^ 4'hF));
         check("ready_inv",  32'(load_ready_inv), 32'(e.rdy));
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [15:0] d);
      int n;
      load_data  = d;
      load_valid = 1'b1;
      n = 0;
      while (load_ready !== 1'b1 && n < 200) begin
         step(1);
         n++;
      end
      if (n >= 200) check("load_accept_timeout", 32'(load_ready), 32'd1);
      step(1);
      load_valid = 1'b0;
      load_data  = 16'($urandom);
      check("ready_drop_after_accept", 32'(load_ready), 32'd0);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (load_ready !== 1'b1 && n < 200) begin
         step(1);
         n++;
      end
      if (n >= 200) check("commit_timeout", 32'(load_ready), 32'd1);
   endtask

   task automatic wait_dig(input logic [3:0] want);
      int n;
      n = 0;
      while (dig_en !== want && n < 100) begin
         step(1);
         n++;
      end
      if (n >= 100) check("wait_dig_timeout", 32'(dig_en), 32'(want));
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      blank_lz   = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      step(3);
      check("reset_seg",     32'(seg),        32'h00);
      check("reset_dig",     32'(dig_en),     32'h0);
      check("reset_seg_inv", 32'(seg_inv),    32'h7F);
      check("reset_dig_inv", 32'(dig_en_inv), 32'hF);
      rst_n  = 1'b1;
      enable = 1'b1;
      step(40);

      // Reset mid-scan must clear outputs without waiting for a clock edge.
      step(5);
      rst_n = 1'b0;
      #1;
      check("async_rst_seg",     32'(seg),            32'h00);
      check("async_rst_dig",     32'(dig_en),         32'h0);
      check("async_rst_ready",   32'(load_ready),     32'd1);
      check("async_rst_seg_inv", 32'(seg_inv),        32'h7F);
      check("async_rst_dig_inv", 32'(dig_en_inv),     32'hF);
      step(2);
      rst_n = 1'b1;
      step(1);
      check("scan_restart", 32'(dig_en), 32'b0001);

      do_load(16'h1234);
      wait_ready();
      wait_dig(4'b0001);
      check("show_1234_slot0", 32'(seg), 32'b0110011);
      wait_dig(4'b1000);
      check("show_1234_slot3", 32'(seg), 32'b0110000);

      blank_lz = 1'b1;
      do_load(16'h0050);
      wait_ready();
      wait_dig(4'b0001);
      check("lz_0050_slot0", 32'(seg), 32'b1111110);
      wait_dig(4'b0010);
      check("lz_0050_slot1", 32'(seg), 32'b1011011);
      wait_dig(4'b0100);
      check("lz_0050_slot2", 32'(seg), 32'h00);
      wait_dig(4'b1000);
      check("lz_0050_slot3", 32'(seg), 32'h00);
      do_load(16'h0000);
      wait_ready();
      wait_dig(4'b0001);
      check("lz_0000_slot0", 32'(seg), 32'b1111110);
      wait_dig(4'b0010);
      check("lz_0000_slot1", 32'(seg), 32'h00);
      blank_lz = 1'b0;

      do_load(16'hA000);
      do_load(16'h9999);
      wait_dig(4'b1000);
      check("dash_slot3", 32'(seg), 32'b0000001);
      wait_ready();
      wait_dig(4'b0001);
      check("nine_slot0", 32'(seg), 32'b1111011);
      wait_dig(4'b1000);
      check("nine_slot3", 32'(seg), 32'b1111011);

      step(6);
      enable = 1'b0;
      step(1);
      check("disable_dig", 32'(dig_en), 32'h0);
      check("disable_seg", 32'(seg),    32'h00);
      do_load(16'h0042);
      step(1);
      check("disabled_commit_ready", 32'(load_ready), 32'd1);
      enable = 1'b1;
      step(1);
      check("reenable_dig", 32'(dig_en), 32'b0001);
      check("reenable_seg", 32'(seg),    32'b1101101);

      do_load(16'h8888);
      wait_ready();
      wait_dig(4'b0001);
      check("inv_eight_seg", 32'(seg_inv),    32'h00);
      check("inv_eight_dig", 32'(dig_en_inv), 32'b1110);

      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 15) == 0) enable = !enable;
         if ($urandom_range(0, 7) == 0) blank_lz = !blank_lz;
         load_valid = ($urandom_range(0, 3) == 0);
         load_data  = 16'($urandom);
         if ($urandom_range(0, 4) == 0) load_data = load_data & 16'h00FF;
         rst_n = ($urandom_range(0, 199) != 0);
         step(1);
      end
      rst_n      = 1'b1;
      load_valid = 1'b0;
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
